// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN,
        MISS,
        HALT
    } fetch_state_e;

    localparam int          INSN_BYTES = 4;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: I-cache request/response plus the bundle handed to ifid.
interface fetch_if;

    logic [63:0] icache_addr;
    logic        icache_hit;
    logic [31:0] icache_data;
    logic        hit;
    logic [63:0] next_pc;
    logic [63:0] next_pcplus4;
    logic [31:0] next_instruction;
    logic        next_noop;

    modport master (
        output icache_addr,
        output hit,
        output next_pc,
        output next_pcplus4,
        output next_instruction,
        output next_noop,
        input  icache_hit,
        input  icache_data
    );

    modport slave (
        input  icache_addr,
        input  hit,
        input  next_pc,
        input  next_pcplus4,
        input  next_instruction,
        input  next_noop,
        output icache_hit,
        output icache_data
    );

endinterface

// File: rtl/pc_next_mux.sv
// Next-PC select: reset, hold, redirect/trap target, pending target, +4.
// IF_MISALIGN_TRAP_EN: misaligned redirect targets resolve to TRAP_PC.
module pc_next_mux
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
`ifdef IF_MISALIGN_TRAP_EN
    ,
    parameter logic [63:0] TRAP_PC  = 64'h100
`endif
) (
    input  logic        reset,
    input  logic        hold,
    input  logic        sel_redirect,
    input  logic        sel_pend,
    input  logic        sel_adv,
    input  logic [63:0] redirect_pc,
    input  logic [63:0] pend_pc,
    input  logic [63:0] pc,
    output logic [63:0] target,
    output logic [63:0] pc_nxt
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    always_comb begin
`ifdef IF_MISALIGN_TRAP_EN
        misalign = |redirect_pc[1:0];
        target   = misalign ? TRAP_PC : redirect_pc;
`else
        target   = redirect_pc & ~64'(INSN_BYTES - 1);
`endif
    end

    // Ordered by priority: a redirect beats a pending target (youngest wins)
    always_comb begin
        pc_nxt = pc;
        if (reset)
            pc_nxt = RESET_PC;
        else if (hold)
            pc_nxt = pc;
        else if (sel_redirect)
            pc_nxt = target;
        else if (sel_pend)
            pc_nxt = pend_pc;
        else if (sel_adv)
            pc_nxt = pc + 64'(INSN_BYTES);
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: sole PC owner, handles stalls, misses, redirects, ecall halt.
// IF_MISALIGN_TRAP_EN: misaligned redirects trap to TRAP_PC and pulse misalign_fault.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
`ifdef IF_MISALIGN_TRAP_EN
    ,
    parameter logic [63:0] TRAP_PC  = 64'h100
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        stall_ecall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    fetch_if.master     fif,
    output logic [63:0] fetch_count
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic        misalign_fault
`endif
);

    fetch_state_e state;
    logic [63:0]  pc;
    logic [63:0]  pend_pc;
    logic [63:0]  pc_nxt;
    logic [63:0]  target;
    logic         pend_valid;
    logic         live;
    logic         eff_redir;
    logic         resolve;
    logic         accept;
    logic         sel_redirect;
    logic         sel_pend;
    logic         sel_adv;
`ifdef IF_MISALIGN_TRAP_EN
    logic         misalign;
`endif

    assign live      = (state != HALT) & ~stall_ecall;
    assign eff_redir = redirect & live;
    assign resolve   = (state == RUN) | fif.icache_hit;

    always_comb begin
        fif.hit       = 1'b1;
        fif.next_noop = 1'b1;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    fif.hit       = fif.icache_hit | eff_redir;
                    fif.next_noop = eff_redir;
                end
                MISS: begin
                    fif.hit       = fif.icache_hit;
                    fif.next_noop = eff_redir | pend_valid;
                end
                default: ;
            endcase
        end
    end

    assign accept       = fif.hit & ~stall;
    assign sel_redirect = eff_redir & resolve;
    assign sel_pend     = live & (state == MISS) & fif.icache_hit & pend_valid;
    assign sel_adv      = live & accept;

    assign fif.icache_addr      = pc;
    assign fif.next_pc          = pc;
    assign fif.next_pcplus4     = pc + 64'(INSN_BYTES);
    assign fif.next_instruction = fif.next_noop ? NOP_INSN : fif.icache_data;

    pc_next_mux #(
        .RESET_PC(RESET_PC)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .TRAP_PC(TRAP_PC)
`endif
    ) u_pc_next_mux (
        .reset       (reset),
        .hold        (~live),
        .sel_redirect(sel_redirect),
        .sel_pend    (sel_pend),
        .sel_adv     (sel_adv),
        .redirect_pc (redirect_pc),
        .pend_pc     (pend_pc),
        .pc          (pc),
        .target      (target),
        .pc_nxt      (pc_nxt)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .misalign    (misalign)
`endif
    );

    always_ff @(posedge clk) begin
        pc <= pc_nxt;
        if (reset) begin
            state       <= RUN;
            pend_valid  <= 1'b0;
            pend_pc     <= '0;
            fetch_count <= '0;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_fault <= 1'b0;
`endif
        end else begin
            fetch_count <= fetch_count + 64'(accept & ~fif.next_noop);
`ifdef IF_MISALIGN_TRAP_EN
            misalign_fault <= eff_redir & misalign;
`endif
            if (!live) begin
                state <= HALT;
            end else begin
                unique case (state)
                    RUN: begin
                        if (!eff_redir && !fif.icache_hit)
                            state <= MISS;
                    end
                    MISS: begin
                        // Redirects during a miss are parked until the word returns
                        if (fif.icache_hit) begin
                            state      <= RUN;
                            pend_valid <= 1'b0;
                        end else if (eff_redir) begin
                            pend_valid <= 1'b1;
                            pend_pc    <= target;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level fetch model.
module tb_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h0;
    localparam logic [63:0] TRP_PC = 64'h100;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        stall_ecall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [63:0] fetch_count;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign_fault;
    bit          m_fault;
`endif

    fetch_if fif ();

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .stall_ecall(stall_ecall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .fif        (fif),
        .fetch_count(fetch_count)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .misalign_fault(misalign_fault)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: where fetch is, whether a word is outstanding, parked target
    logic [63:0] m_pc;
    logic [63:0] m_pend;
    logic [63:0] m_count;
    bit          m_halt;
    bit          m_wait;
    bit          m_has_pend;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] tgt_of(logic [63:0] a);
`ifdef IF_MISALIGN_TRAP_EN
        return (a % 4 != 0) ? TRP_PC : a;
`else
        return a - (a % 4);
`endif
    endfunction

    task automatic model_reset();
        m_pc       = RST_PC;
        m_pend     = '0;
        m_count    = '0;
        m_halt     = 0;
        m_wait     = 0;
        m_has_pend = 0;
`ifdef IF_MISALIGN_TRAP_EN
        m_fault    = 0;
`endif
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        stall           = 1'($urandom);
        stall_ecall     = 1'($urandom);
        redirect        = 1'($urandom);
        redirect_pc     = {$urandom, $urandom};
        fif.icache_hit  = 1'($urandom);
        fif.icache_data = $urandom;
        @(negedge clk);
        check("rst_hit", 64'(fif.hit), 64'd1);
        check("rst_noop", 64'(fif.next_noop), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic step(bit s, bit e, bit r, logic [63:0] rpc, bit ih);
        bit eh;
        bit en;
        bit lr;
        bit acc;
        stall           = s;
        stall_ecall     = e;
        redirect        = r;
        redirect_pc     = rpc;
        fif.icache_hit  = ih;
        fif.icache_data = $urandom;
        @(negedge clk);
        lr = r && !e && !m_halt;
        if (m_halt) begin
            eh = 1; en = 1;
        end else if (!m_wait) begin
            eh = ih || lr; en = lr;
        end else begin
            eh = ih; en = lr || m_has_pend;
        end
        check("hit", 64'(fif.hit), 64'(eh));
        check("noop", 64'(fif.next_noop), 64'(en));
        check("addr", fif.icache_addr, m_pc);
        check("pc", fif.next_pc, m_pc);
        check("pc4", fif.next_pcplus4, m_pc + 4);
        check("count", fetch_count, m_count);
        if (eh && !en)
            check("insn", 64'(fif.next_instruction), 64'(fif.icache_data));
`ifdef IF_MISALIGN_TRAP_EN
        check("fault", 64'(misalign_fault), 64'(m_fault));
        m_fault = lr && (rpc % 4 != 0);
`endif
        acc = eh && !s;
        if (acc && !en)
            m_count = m_count + 1;
        if (m_halt) begin
        end else if (e) begin
            m_halt = 1;
        end else if (!m_wait) begin
            if (lr)
                m_pc = tgt_of(rpc);
            else if (!ih)
                m_wait = 1;
            else if (!s)
                m_pc = m_pc + 4;
        end else if (ih) begin
            m_wait = 0;
            if (lr)
                m_pc = tgt_of(rpc);
            else if (m_has_pend)
                m_pc = m_pend;
            else if (!s)
                m_pc = m_pc + 4;
            m_has_pend = 0;
        end else if (lr) begin
            m_has_pend = 1;
            m_pend     = tgt_of(rpc);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        do_reset();
        check("t0_pc", fif.next_pc, 64'h0);
        check("t0_cnt", fetch_count, 64'd0);

        repeat (4) step(0, 0, 0, 64'h0, 1);
        check("t1_cnt", fetch_count, 64'd4);
        check("t1_pc", fif.next_pc, 64'h10);

        repeat (3) step(1, 0, 0, 64'h0, 1);
        check("t2_pc", fif.next_pc, 64'h10);
        check("t2_cnt", fetch_count, 64'd4);

        repeat (3) step(0, 0, 0, 64'h0, 0);
        check("t3_hit", 64'(fif.hit), 64'd0);
        check("t3_addr", fif.icache_addr, 64'h10);
        step(0, 0, 0, 64'h0, 1);
        check("t3_pc", fif.next_pc, 64'h14);
        check("t3_cnt", fetch_count, 64'd5);

        step(0, 0, 1, 64'h200, 1);
        check("t4_pc", fif.next_pc, 64'h200);
        check("t4_cnt", fetch_count, 64'd5);
        step(0, 0, 0, 64'h0, 1);

        step(0, 0, 0, 64'h0, 0);
        step(0, 0, 1, 64'h300, 0);
        step(0, 0, 1, 64'h340, 0);
        check("t5_addr", fif.icache_addr, 64'h204);
        step(0, 0, 0, 64'h0, 1);
        check("t5_pc", fif.next_pc, 64'h340);
        check("t5_cnt", fetch_count, 64'd6);

        step(0, 1, 1, 64'h500, 1);
        repeat (3) step(1'($urandom), 0, 1'($urandom), 64'h600, 1'($urandom));
        check("t6_pc", fif.next_pc, 64'h340);
        check("t6_cnt", fetch_count, 64'd7);
        do_reset();
        check("t6_rst", fif.next_pc, RST_PC);

        step(0, 0, 1, 64'h202, 1);
`ifdef IF_MISALIGN_TRAP_EN
        check("t6_trap", fif.next_pc, TRP_PC);
        check("t6_flt", 64'(misalign_fault), 64'd1);
`else
        check("t6_align", fif.next_pc, 64'h200);
`endif

        for (int i = 0; i < 3000; i++) begin
            if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0)
                do_reset();
            else
                step($urandom_range(0, 3) == 0,
                     $urandom_range(0, 199) == 0,
                     $urandom_range(0, 7) == 0,
                     $urandom_range(0, 1) == 0 ? {$urandom, $urandom}
                                               : 64'($urandom_range(0, 4095)),
                     $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
